ultrasonic_ranger_mc: RTL

- Multi-channel successor to the single-sensor ultrasonic rangefinder path.
- Round-robins NUM_CH HC-SR04-style sensors. For each channel in turn it fires a trigger pulse, measures the echo high time and converts it to millimetres with a prescaler (no divider).
- Detects missing or overlong echoes and reports them as timeouts.
- Emits one result per slot as a valid-pulsed stream (channel, distance, timeout) for downstream display/averaging logic.

---
 rtl/ultrasonic_ranger_mc.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_ranger_mc.sv
// Round-robin HC-SR04 ranger: triggers each channel in turn, times the echo and
// streams one (channel, mm, timeout) result per slot.
module ultrasonic_ranger_mc #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned TRIG_CYCLES    = 500,
  parameter int unsigned CYC_PER_MM     = 292,
  parameter int unsigned TIMEOUT_CYCLES = 1500000,
  parameter int unsigned PERIOD_CYCLES  = 3000000,
  parameter int unsigned DIST_W         = 13,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] echo,
  output logic [NUM_CH-1:0] trigger,
  output logic              dist_valid,
  output logic [CH_W-1:0]   dist_ch,
  output logic [DIST_W-1:0] dist_data,
  output logic              dist_timeout,
  output logic              busy
);

  localparam int unsigned SLOT_W = $clog2(PERIOD_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned PRE_W  = (CYC_PER_MM > 1) ? $clog2(CYC_PER_MM) : 1;

  localparam logic [SLOT_W-1:0] SLOT_TRIG_END = SLOT_W'(TRIG_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST     = SLOT_W'(PERIOD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST      = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST      = PRE_W'(CYC_PER_MM - 1);
  localparam logic [CH_W-1:0]   CH_LAST       = CH_W'(NUM_CH - 1);
  // All-ones is reserved for timeout, so real distances clamp one below.
  localparam logic [DIST_W-1:0] DIST_SAT      = {{(DIST_W-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    REPORT,
    HOLDOFF
  } state_t;

  state_t              state;
  logic [CH_W-1:0]     ch;
  logic [SLOT_W-1:0]   slot_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [PRE_W-1:0]    presc;
  logic [DIST_W-1:0]   dist_cnt;

  logic [NUM_CH-1:0]   echo_m;
  logic [NUM_CH-1:0]   echo_s;
  logic [NUM_CH-1:0]   echo_p;
  logic                echo_cur;
  logic                echo_prev;
  logic                echo_rise;
  logic                echo_fall;

  // Two-flop synchroniser plus previous-value register for every echo line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      echo_m <= '0;
      echo_s <= '0;
      echo_p <= '0;
    end else begin
      echo_m <= echo;
      echo_s <= echo_m;
      echo_p <= echo_s;
    end
  end

  assign echo_cur  = echo_s[ch];
  assign echo_prev = echo_p[ch];
  assign echo_rise = echo_cur & ~echo_prev;
  assign echo_fall = echo_prev & ~echo_cur;

  // Slot sequencer, echo timing and result register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ch           <= '0;
      slot_cnt     <= '0;
      tmo_cnt      <= '0;
      presc        <= '0;
      dist_cnt     <= '0;
      trigger      <= '0;
      dist_valid   <= 1'b0;
      dist_ch      <= '0;
      dist_data    <= '0;
      dist_timeout <= 1'b0;
      busy         <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      if (state != IDLE && slot_cnt != SLOT_LAST) begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state    <= TRIG;
            slot_cnt <= '0;
            busy     <= 1'b1;
          end
        end

        TRIG: begin
          if (slot_cnt == SLOT_TRIG_END) begin
            trigger <= '0;
            tmo_cnt <= '0;
            state   <= WAIT_RISE;
          end else begin
            trigger <= NUM_CH'(1) << ch;
          end
        end

        WAIT_RISE: begin
          if (echo_rise) begin
            // The rise clock is already the first echo-high clock.
            presc    <= '0;
            dist_cnt <= '0;
            tmo_cnt  <= TMO_W'(1);
            state    <= MEASURE;
          end else if (tmo_cnt >= TMO_LAST) begin
            dist_valid   <= 1'b1;
            dist_timeout <= 1'b1;
            dist_data    <= '1;
            dist_ch      <= ch;
            state        <= HOLDOFF;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        MEASURE: begin
          if (echo_fall) begin
            state <= REPORT;
          end else if (tmo_cnt >= TMO_LAST) begin
            dist_valid   <= 1'b1;
            dist_timeout <= 1'b1;
            dist_data    <= '1;
            dist_ch      <= ch;
            state        <= HOLDOFF;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (presc == PRE_LAST) begin
              presc <= '0;
              if (dist_cnt != DIST_SAT) begin
                dist_cnt <= dist_cnt + DIST_W'(1);
              end
            end else begin
              presc <= presc + PRE_W'(1);
            end
          end
        end

        REPORT: begin
          dist_valid   <= 1'b1;
          dist_timeout <= 1'b0;
          dist_data    <= dist_cnt;
          dist_ch      <= ch;
          state        <= HOLDOFF;
        end

        HOLDOFF: begin
          if (slot_cnt >= SLOT_LAST) begin
            ch <= (ch == CH_LAST) ? '0 : ch + CH_W'(1);
            if (enable) begin
              state    <= TRIG;
              slot_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state   <= IDLE;
          trigger <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
